// File: rtl/button_pkg.sv
// button_pkg
//   Shared types and constants for the push-button input path.
//   - btn_state_t     : debounce FSM states
//   - BTN_COUNT_W     : width of the press counter in the status word
//   - BTN_PENDING_BIT : bit position of the pending flag in the status word
package button_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } btn_state_t;

  localparam int BTN_COUNT_W     = 16;
  localparam int BTN_PENDING_BIT = 31;

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
//   Two-flop synchronizer followed by a debounce FSM. A level change is
//   accepted only after DEBOUNCE_CYCLES consecutive synchronized samples at
//   the new level.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   button : raw asynchronous push-button level (1 = pressed)
//   level  : debounced level (1 in HIGH and FALL_WAIT)
//   accept : one-cycle event, high in the cycle whose closing edge moves the
//            FSM from RISE_WAIT to HIGH; consumers register it on that edge
module button_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic accept
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s;
  btn_state_t       state;
  btn_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  // Two-stage synchronizer; s is the first flop safe to use in logic.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= button;
      s  <= s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // cnt holds the number of consecutive samples seen at the candidate level,
  // so the sample that finds cnt == DEBOUNCE_CYCLES-1 is the last one needed.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nx = state;
    cnt_nx   = '0;
    accept   = 1'b0;
    unique case (state)
      LOW: begin
        if (s) begin
          state_nx = RISE_WAIT;
          cnt_nx   = CNT_W'(1);
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_nx = LOW;
        end else if (cnt == LAST_CNT) begin
          state_nx = HIGH;
          accept   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_nx = FALL_WAIT;
          cnt_nx   = CNT_W'(1);
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_nx = HIGH;
        end else if (cnt == LAST_CNT) begin
          state_nx = LOW;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = LOW;
    endcase
  end

  assign level = (state == HIGH) || (state == FALL_WAIT);

endmodule

// File: rtl/button_press_register.sv
// button_press_register
//   Debounces the board push-button, counts accepted presses and packs a
//   processor-readable status word. An ack pulse clears the word; a press
//   accepted in the same cycle as ack survives as a count of one.
// Ports:
//   clock         : system clock, rising edge
//   reset         : asynchronous, active-low
//   button        : raw asynchronous push-button level
//   ack           : one-cycle acknowledge from the processor side
//   buttonPressed : {pending, 15'b0, press_count[15:0]}
//   level         : debounced button level
//   press_pulse   : one-cycle strobe per accepted press
module button_press_register
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        button,
  input  logic        ack,
  output logic [31:0] buttonPressed,
  output logic        level,
  output logic        press_pulse
);

  localparam int PAD_W = BTN_PENDING_BIT - BTN_COUNT_W;

  logic                   accept;
  logic                   pending;
  logic [BTN_COUNT_W-1:0] press_count;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debouncer (
    .clock (clock),
    .reset (reset),
    .button(button),
    .level (level),
    .accept(accept)
  );

  // ack has priority over the old count but never swallows a new press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      press_pulse <= 1'b0;
      pending     <= 1'b0;
      press_count <= '0;
    end else begin
      press_pulse <= accept;
      if (ack && accept) begin
        press_count <= BTN_COUNT_W'(1);
        pending     <= 1'b1;
      end else if (ack) begin
        press_count <= '0;
        pending     <= 1'b0;
      end else if (accept) begin
        // Saturate rather than wrap so software never sees a bogus small count.
        if (press_count != '1) begin
          press_count <= press_count + BTN_COUNT_W'(1);
        end
        pending <= 1'b1;
      end
    end
  end

  assign buttonPressed = {pending, {PAD_W{1'b0}}, press_count};

endmodule

// File: tb/tb_button_press_register.sv
// tb_button_press_register
//   Randomized and directed stimulus against a behavioural model: the
//   debounced level flips once DEBOUNCE_CYCLES consecutive synchronized
//   samples disagree with it; presses are counted with saturation and
//   cleared by ack.
module tb_button_press_register;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        button;
  logic        ack;
  logic [31:0] buttonPressed;
  logic        level;
  logic        press_pulse;

  int n_checks  = 0;
  int n_pass    = 0;
  int pulse_cnt = 0;

  button_press_register #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button       (button),
    .ack          (ack),
    .buttonPressed(buttonPressed),
    .level        (level),
    .press_pulse  (press_pulse)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  bit m_s1, m_s, m_level, m_pulse, m_pending, m_acc;
  int m_run, m_count;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_s1 = 0; m_s = 0; m_level = 0; m_pulse = 0; m_pending = 0;
      m_run = 0; m_count = 0;
    end else begin
      m_acc = 0;
      if (m_s != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = !m_level;
          m_run   = 0;
          m_acc   = m_level;
        end
      end else begin
        m_run = 0;
      end
      m_s  = m_s1;
      m_s1 = button;
      m_pulse = m_acc;
      if (ack) begin
        m_count   = m_acc ? 1 : 0;
        m_pending = m_acc;
      end else if (m_acc) begin
        m_count   = (m_count < 65535) ? m_count + 1 : 65535;
        m_pending = 1;
      end
    end
  end

  function automatic logic [31:0] model_word();
    logic [15:0] c;
    c = m_count[15:0];
    return {m_pending, 15'b0, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    check("cmp_word",  buttonPressed,      model_word());
    check("cmp_level", {31'b0, level},      {31'b0, m_level});
    check("cmp_pulse", {31'b0, press_pulse}, {31'b0, m_pulse});
    if (press_pulse) pulse_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press();
    button = 1'b1;
    repeat (10) step();
    button = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    reset  = 1'b1;
    button = 1'b0;
    ack    = 1'b0;
    #1 reset = 1'b0;

    // Reset held: toggling button must not move any output.
    for (int i = 0; i < 6; i++) begin
      step();
      button = ~button;
      check("rst_word",  buttonPressed, 32'h0);
      check("rst_level", {31'b0, level}, 32'h0);
      check("rst_pulse", {31'b0, press_pulse}, 32'h0);
    end
    step();
    button = 1'b0;
    step();
    reset = 1'b1;
    repeat (4) step();

    // Clean press: accepted at edge 6.
    button = 1'b1;
    edges(5);
    check("press_level_early", {31'b0, level}, 32'h0);
    edges(1);
    check("press_level", {31'b0, level}, 32'h1);
    check("press_pulse", {31'b0, press_pulse}, 32'h1);
    check("press_word",  buttonPressed, 32'h8000_0001);
    edges(1);
    check("press_pulse_end", {31'b0, press_pulse}, 32'h0);

    // Release: level falls six edges later, word unchanged.
    step();
    button = 1'b0;
    edges(5);
    check("rel_level_early", {31'b0, level}, 32'h1);
    edges(1);
    check("rel_level", {31'b0, level}, 32'h0);
    check("rel_word",  buttonPressed, 32'h8000_0001);
    repeat (3) step();

    // Bounce: 3 high, 1 low, then held high -> exactly one press.
    pulse_cnt = 0;
    button = 1'b1;
    repeat (3) step();
    button = 1'b0;
    step();
    button = 1'b1;
    repeat (12) step();
    check("bounce_pulses", pulse_cnt, 32'd1);
    check("bounce_word",   buttonPressed, 32'h8000_0002);
    button = 1'b0;
    repeat (12) step();

    // Ack from count 3.
    press();
    check("cnt3_word", buttonPressed, 32'h8000_0003);
    ack = 1'b1;
    edges(1);
    check("ack_clear", buttonPressed, 32'h0);
    step();
    ack = 1'b0;
    step();
    ack = 1'b1;
    edges(1);
    check("ack_idle", buttonPressed, 32'h0);
    step();
    ack = 1'b0;

    // Ack coinciding with an accept keeps the new press.
    press();
    check("pre_coinc_word", buttonPressed, 32'h8000_0001);
    step();
    button = 1'b1;
    edges(5);
    ack = 1'b1;
    edges(1);
    check("coinc_word",  buttonPressed, 32'h8000_0001);
    check("coinc_pulse", {31'b0, press_pulse}, 32'h1);
    step();
    ack    = 1'b0;
    button = 1'b0;
    repeat (10) step();

    // Saturation: preload near the top, then press past it.
    force dut.press_count = 16'hFFFD;
    m_count = 65533;
    #1 release dut.press_count;
    step();
    check("preload_word", buttonPressed, 32'h8000_FFFD);
    press();
    check("sat_fffe", buttonPressed, 32'h8000_FFFE);
    press();
    check("sat_ffff", buttonPressed, 32'h8000_FFFF);
    press();
    check("sat_hold", buttonPressed, 32'h8000_FFFF);

    // Reset during RISE_WAIT with button held.
    step();
    button = 1'b1;
    edges(3);
    reset = 1'b0;
    #1;
    check("midrst_word",  buttonPressed, 32'h0);
    check("midrst_level", {31'b0, level}, 32'h0);
    check("midrst_pulse", {31'b0, press_pulse}, 32'h0);
    step();
    step();
    reset = 1'b1;
    edges(5);
    check("postrst_level_early", {31'b0, level}, 32'h0);
    edges(1);
    check("postrst_level", {31'b0, level}, 32'h1);
    check("postrst_word",  buttonPressed, 32'h8000_0001);
    button = 1'b0;
    repeat (10) step();

    // Randomized segments: bounces, long holds, random acks, rare resets.
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      button = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 14);
      for (int c = 0; c < len; c++) begin
        ack   = ($urandom_range(0, 7) == 0);
        reset = ($urandom_range(0, 299) != 0);
        step();
      end
    end

    ack    = 1'b0;
    reset  = 1'b1;
    button = 1'b0;
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
